// File: rtl/debounce_pkg.sv
// Shared constants and helpers for the multi-channel debounce filter.
package debounce_pkg;

    localparam int unsigned DEFAULT_DEBOUNCE_LIMIT = 120000;
    localparam int unsigned DEFAULT_HOLD_LIMIT     = 1200000;

    // Short limits that keep simulation runs small.
    localparam int unsigned TEST_NUM_CH         = 4;
    localparam int unsigned TEST_DEBOUNCE_LIMIT = 4;
    localparam int unsigned TEST_HOLD_LIMIT     = 10;

    // Bits needed to hold 0..limit; never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned limit);
        return (limit == 0) ? 1 : 32'($clog2(limit + 1));
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: optional synchroniser, debounce filter, edge strobes, hold detector.
// DEBOUNCE_SYNC_EN adds a 2-flop input synchroniser (2 extra cycles of latency).
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_LIMIT = DEFAULT_DEBOUNCE_LIMIT,
    parameter int unsigned HOLD_LIMIT     = DEFAULT_HOLD_LIMIT,
    parameter logic        INVERT         = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn,
    output logic o_btn,
    output logic o_press,
    output logic o_release,
    output logic o_hold
);

    localparam int unsigned       DW      = cnt_width(DEBOUNCE_LIMIT);
    localparam logic [DW-1:0]     DB_LAST = DW'(DEBOUNCE_LIMIT - 1);

    logic w_x;

`ifdef DEBOUNCE_SYNC_EN
    logic r_sync1;
    logic r_sync2;

    // Reset to INVERT so the filtered sample starts at 0.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sync1 <= INVERT;
            r_sync2 <= INVERT;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
        end
    end

    assign w_x = r_sync2 ^ INVERT;
`else
    assign w_x = i_btn ^ INVERT;
`endif

    logic          r_state;
    logic          r_press;
    logic          r_release;
    logic [DW-1:0] r_db_cnt;

    // Level flips after DEBOUNCE_LIMIT consecutive disagreeing samples.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state   <= 1'b0;
            r_db_cnt  <= '0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_press   <= 1'b0;
            r_release <= 1'b0;
            if (w_x == r_state) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == DB_LAST) begin
                r_state   <= w_x;
                r_db_cnt  <= '0;
                r_press   <= w_x;
                r_release <= ~w_x;
            end else begin
                r_db_cnt <= r_db_cnt + DW'(1);
            end
        end
    end

    assign o_btn     = r_state;
    assign o_press   = r_press;
    assign o_release = r_release;

    if (HOLD_LIMIT == 0) begin : g_no_hold
        assign o_hold = 1'b0;
    end else begin : g_hold
        localparam int unsigned   HW       = cnt_width(HOLD_LIMIT);
        localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_LIMIT);

        logic [HW-1:0] r_hold_cnt;
        logic          r_hold;

        // Saturating count of filtered-high cycles; strobes once on reaching the limit.
        always_ff @(posedge i_clk) begin
            if (!i_rst_n) begin
                r_hold_cnt <= '0;
                r_hold     <= 1'b0;
            end else begin
                r_hold <= 1'b0;
                if (!r_state) begin
                    r_hold_cnt <= '0;
                end else if (r_hold_cnt < HOLD_MAX) begin
                    r_hold_cnt <= r_hold_cnt + HW'(1);
                    r_hold     <= (r_hold_cnt == HOLD_MAX - HW'(1));
                end
            end
        end

        assign o_hold = r_hold;
    end

endmodule

// File: rtl/debounce_multi.sv
// NUM_CH independent debounce channels with press/release/hold strobes.
// Define DEBOUNCE_SYNC_EN to add a 2-flop synchroniser on every input.
module debounce_multi
    import debounce_pkg::*;
#(
    parameter int unsigned       NUM_CH         = 4,
    parameter int unsigned       DEBOUNCE_LIMIT = DEFAULT_DEBOUNCE_LIMIT,
    parameter int unsigned       HOLD_LIMIT     = DEFAULT_HOLD_LIMIT,
    parameter logic [NUM_CH-1:0] INVERT         = '0
) (
    input  logic              CLK,
    input  logic              i_RST_N,
    input  logic [NUM_CH-1:0] i_BTN,
    output logic [NUM_CH-1:0] o_BTN,
    output logic [NUM_CH-1:0] o_PRESS,
    output logic [NUM_CH-1:0] o_RELEASE,
    output logic [NUM_CH-1:0] o_HOLD
);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_LIMIT (DEBOUNCE_LIMIT),
            .HOLD_LIMIT     (HOLD_LIMIT),
            .INVERT         (INVERT[c])
        ) u_ch (
            .i_clk     (CLK),
            .i_rst_n   (i_RST_N),
            .i_btn     (i_BTN[c]),
            .o_btn     (o_BTN[c]),
            .o_press   (o_PRESS[c]),
            .o_release (o_RELEASE[c]),
            .o_hold    (o_HOLD[c])
        );
    end

endmodule

// File: tb/tb_debounce_multi.sv
// Scoreboard bench for debounce_multi: directed scenarios plus randomized bouncing inputs.
module tb_debounce_multi;
    import debounce_pkg::*;

    localparam int NCH = int'(TEST_NUM_CH);
    localparam int DL  = int'(TEST_DEBOUNCE_LIMIT);
    localparam int HL  = int'(TEST_HOLD_LIMIT);
`ifdef DEBOUNCE_SYNC_EN
    localparam int SYNC_DLY = 2;
`else
    localparam int SYNC_DLY = 0;
`endif
    localparam int         LAT  = DL + SYNC_DLY;
    localparam logic [3:0] INV  = 4'b1000;
    localparam logic [3:0] IDLE = INV;

    logic       CLK;
    logic       i_RST_N;
    logic [3:0] i_BTN;
    logic [3:0] o_BTN;
    logic [3:0] o_PRESS;
    logic [3:0] o_RELEASE;
    logic [3:0] o_HOLD;

    debounce_multi #(
        .NUM_CH         (NCH),
        .DEBOUNCE_LIMIT (DL),
        .HOLD_LIMIT     (HL),
        .INVERT         (INV)
    ) dut (
        .CLK       (CLK),
        .i_RST_N   (i_RST_N),
        .i_BTN     (i_BTN),
        .o_BTN     (o_BTN),
        .o_PRESS   (o_PRESS),
        .o_RELEASE (o_RELEASE),
        .o_HOLD    (o_HOLD)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        int         cyc;
        logic [3:0] btn;
        logic [3:0] press;
        logic [3:0] rel;
        logic [3:0] hold;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   edge_n = 0;
    bit   mon_en = 1'b1;

    // Reference model state: level, recent samples, pending hold per channel.
    logic [3:0] m_level = '0;
    bit         m_hist[NCH][$];
    bit         m_armed[NCH] = '{default: 1'b0};
    int         m_press_cyc[NCH] = '{default: 0};
`ifdef DEBOUNCE_SYNC_EN
    logic [3:0] m_p1 = '0;
    logic [3:0] m_p2 = '0;
`endif

    // Event statistics observed from the DUT.
    int n_press[NCH]   = '{default: 0};
    int n_rel[NCH]     = '{default: 0};
    int n_hold[NCH]    = '{default: 0};
    int last_press[NCH] = '{default: -1000};
    int last_rel[NCH]   = '{default: -1000};
    int last_hold[NCH]  = '{default: -1000};

    // A level flips once the last DL samples all disagree with it; hold fires HL
    // edges after a press if the level stayed high throughout.
    task automatic model_edge(input logic [3:0] b, input logic rst_n, input int k);
        exp_t       e;
        logic [3:0] x;
        logic [3:0] xu;
        bit         all_diff;
        e.cyc   = k;
        e.press = '0;
        e.rel   = '0;
        e.hold  = '0;
        if (!rst_n) begin
            m_level = '0;
`ifdef DEBOUNCE_SYNC_EN
            m_p1 = '0;
            m_p2 = '0;
`endif
            for (int c = 0; c < NCH; c++) begin
                m_armed[c] = 1'b0;
                m_hist[c].delete();
            end
        end else begin
            x = b ^ INV;
`ifdef DEBOUNCE_SYNC_EN
            xu   = m_p2;
            m_p2 = m_p1;
            m_p1 = x;
`else
            xu = x;
`endif
            for (int c = 0; c < NCH; c++) begin
                if (m_level[c] && m_armed[c] && (k - m_press_cyc[c]) == HL) begin
                    e.hold[c]  = 1'b1;
                    m_armed[c] = 1'b0;
                end
                m_hist[c].push_back(xu[c]);
                if (m_hist[c].size() > DL) void'(m_hist[c].pop_front());
                if (m_hist[c].size() == DL) begin
                    all_diff = 1'b1;
                    for (int j = 0; j < m_hist[c].size(); j++)
                        if (m_hist[c][j] == m_level[c]) all_diff = 1'b0;
                    if (all_diff) begin
                        m_level[c] = ~m_level[c];
                        if (m_level[c]) begin
                            e.press[c]     = 1'b1;
                            m_press_cyc[c] = k;
                            m_armed[c]     = (HL != 0);
                        end else begin
                            e.rel[c]   = 1'b1;
                            m_armed[c] = 1'b0;
                        end
                    end
                end
            end
        end
        e.btn = m_level;
        exp_q.push_back(e);
    endtask

    task automatic step(input logic [3:0] b, input logic rst_n);
        @(negedge CLK);
        i_BTN   = b;
        i_RST_N = rst_n;
        model_edge(b, rst_n, edge_n + 1);
        @(posedge CLK);
        edge_n++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pop the expected response for every edge and compare.
    initial begin
        forever begin
            @(negedge CLK);
            if (mon_en && edge_n > 0) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL scoreboard_underflow at cycle %0d", edge_n);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mon_e.cyc != edge_n || o_BTN !== mon_e.btn || o_PRESS !== mon_e.press ||
                        o_RELEASE !== mon_e.rel || o_HOLD !== mon_e.hold) begin
                        errors++;
                        $display("FAIL scoreboard cycle %0d: got btn=%h press=%h rel=%h hold=%h, expected (cycle %0d) btn=%h press=%h rel=%h hold=%h",
                                 edge_n, o_BTN, o_PRESS, o_RELEASE, o_HOLD,
                                 mon_e.cyc, mon_e.btn, mon_e.press, mon_e.rel, mon_e.hold);
                    end
                end
                for (int c = 0; c < NCH; c++) begin
                    if (o_PRESS[c] === 1'b1)   begin n_press[c]++; last_press[c] = edge_n; end
                    if (o_RELEASE[c] === 1'b1) begin n_rel[c]++;   last_rel[c]   = edge_n; end
                    if (o_HOLD[c] === 1'b1)    begin n_hold[c]++;  last_hold[c]  = edge_n; end
                end
            end
        end
    end

    int         start;
    int         s_p0, s_p1, s_p3, s_r2, s_p2, s_h1, s_h2;
    bit         low_ok;
    logic [3:0] cur;
    int unsigned rate;

    initial begin
        i_RST_N = 1'b0;
        i_BTN   = 4'hF;

        // Reset with all raw inputs high, then release.
        repeat (3) step(4'hF, 1'b0);
        #1 chk("reset_outputs", 32'({o_BTN, o_PRESS, o_RELEASE, o_HOLD}), 32'h0);
        repeat (LAT - 1) step(4'hF, 1'b1);
        #1 chk("reset_release_no_early_flip", 32'(o_BTN), 32'h0);
        step(4'hF, 1'b1);
        #1 chk("reset_release_btn", 32'(o_BTN), 32'(4'hF ^ INV));
        chk("reset_release_press", 32'(o_PRESS), 32'(4'hF ^ INV));
        step(4'hF, 1'b1);
        #1 chk("press_one_cycle", 32'(o_PRESS), 32'h0);
        repeat (LAT + 1) step(IDLE, 1'b1);

        // Bounce on ch0: 1,1,1,0 then steady 1.
        low_ok = 1'b1;
        for (int i = 0; i < 4 + LAT; i++) begin
            step(IDLE ^ {3'b000, (i != 3)}, 1'b1);
            #1 if (i < 3 + LAT && o_BTN[0] !== 1'b0) low_ok = 1'b0;
        end
        chk("bounce_no_early_rise", 32'(low_ok), 32'd1);
        chk("bounce_rise_btn", 32'(o_BTN[0]), 32'd1);
        chk("bounce_rise_press", 32'(o_PRESS[0]), 32'd1);
        step(IDLE ^ 4'b0001, 1'b1);
        #1 chk("bounce_press_width", 32'(o_PRESS[0]), 32'd0);
        repeat (LAT + 1) step(IDLE, 1'b1);

        // Long press on ch1.
        s_h1  = n_hold[1];
        start = edge_n + 1;
        repeat (24) step(IDLE ^ 4'b0010, 1'b1);
        #1 chk("hold_press_latency", 32'(last_press[1] - start + 1), 32'(LAT));
        chk("hold_after_press", 32'(last_hold[1] - last_press[1]), 32'(HL));
        chk("hold_single_pulse", 32'(n_hold[1] - s_h1), 32'd1);
        start = edge_n + 1;
        repeat (LAT + 2) step(IDLE, 1'b1);
        #1 chk("release_latency", 32'(last_rel[1] - start + 1), 32'(LAT));

        // Short press on ch2 must not produce a hold.
        s_p2 = n_press[2];
        s_r2 = n_rel[2];
        s_h2 = n_hold[2];
        repeat (8) step(IDLE ^ 4'b0100, 1'b1);
        repeat (LAT + HL + 2) step(IDLE, 1'b1);
        #1 chk("short_press", 32'(n_press[2] - s_p2), 32'd1);
        chk("short_release", 32'(n_rel[2] - s_r2), 32'd1);
        chk("short_no_hold", 32'(n_hold[2] - s_h2), 32'd0);

        // Inverted ch3 pressed together with ch0.
        chk("invert_idle_low", 32'(o_BTN[3]), 32'd0);
        s_p0  = n_press[0];
        s_p3  = n_press[3];
        start = edge_n + 1;
        repeat (LAT + 1) step(IDLE ^ 4'b1001, 1'b1);
        #1 chk("invert_press", 32'(n_press[3] - s_p3), 32'd1);
        chk("simul_press_ch0", 32'(n_press[0] - s_p0), 32'd1);
        chk("simul_same_cycle", 32'(last_press[3]), 32'(last_press[0]));
        chk("invert_press_latency", 32'(last_press[3] - start + 1), 32'(LAT));
        chk("invert_btn", 32'(o_BTN[3]), 32'd1);
        repeat (LAT + HL + 2) step(IDLE, 1'b1);

        // Reset in the middle of a ch1 count discards it.
        repeat (LAT - 1) step(IDLE ^ 4'b0010, 1'b1);
        step(IDLE ^ 4'b0010, 1'b0);
        s_p1 = n_press[1];
        repeat (LAT - 1) step(IDLE ^ 4'b0010, 1'b1);
        #1 chk("reset_discard_btn", 32'(o_BTN[1]), 32'd0);
        chk("reset_discard_no_press", 32'(o_PRESS[1]), 32'd0);
        step(IDLE ^ 4'b0010, 1'b1);
        #1 chk("reset_then_press", 32'(o_PRESS[1]), 32'd1);
        repeat (LAT + 1) step(IDLE, 1'b1);

        // Randomized bouncing with varying toggle rates and occasional resets.
        cur = IDLE;
        for (int seg = 0; seg < 12; seg++) begin
            rate = (seg % 3 == 0) ? 3 : ((seg % 3 == 1) ? 9 : 30);
            for (int i = 0; i < 50; i++) begin
                for (int c = 0; c < NCH; c++)
                    if ($urandom_range(rate - 1, 0) == 0) cur[c] = ~cur[c];
                if ($urandom_range(149, 0) == 0) step(cur, 1'b0);
                else                             step(cur, 1'b1);
            end
        end
        repeat (LAT + HL + 2) step(IDLE, 1'b1);

        @(negedge CLK);
        #1;
        mon_en = 1'b0;
        chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
